// File: rtl/tc_pkg.sv
// ---------------------------------------------------------------------------
// tc_pkg
// Shared constants and helpers for the timestamp counter.
//   SEC_MAX_DEF / MIN_MAX_DEF / HR_MAX_DEF : default last value of each field
//   tc_cnt_w()                             : bit width for a 0..n-1 counter
// ---------------------------------------------------------------------------
package tc_pkg;

    localparam int SEC_MAX_DEF = 59;
    localparam int MIN_MAX_DEF = 59;
    localparam int HR_MAX_DEF  = 23;

    localparam int SEC_W_DEF = 6;
    localparam int MIN_W_DEF = 6;
    localparam int HR_W_DEF  = 5;

    // Width of a counter that must hold 0..n-1; never narrower than 1 bit.
    function automatic int tc_cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tc_prescaler.sv
// ---------------------------------------------------------------------------
// tc_prescaler
// Divides enabled clock cycles by PRESCALE and emits a one-cycle inc on the
// last cycle of each period.
//   clk   in  system clock
//   reset in  synchronous active-high reset, clears the phase counter
//   en    in  advance enable; the phase counter holds when low
//   clr   in  restart the period (preload); suppresses inc in that cycle
//   inc   out combinational: one time unit has elapsed this cycle
// ---------------------------------------------------------------------------
module tc_prescaler
    import tc_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic inc
);

    localparam int            PW        = tc_cnt_w(PRESCALE);
    localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt_q;
    logic [PW-1:0] pcnt_d;
    logic          term;

    // With PRESCALE==1 the counter sits at 0, term is always true, so inc=en.
    assign term = (pcnt_q == PCNT_LAST);
    assign inc  = en && !clr && term;

    always_comb begin
        pcnt_d = pcnt_q;
        if (clr) begin
            pcnt_d = '0;
        end else if (en) begin
            pcnt_d = term ? '0 : pcnt_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/timestamp_counter.sv
// ---------------------------------------------------------------------------
// timestamp_counter
// hr:min:sec elapsed-time counter used to stamp spectrogram frame headers.
// Prescaled count enable, synchronous preload with clamping, wrap or
// saturate at full scale, and a sticky overflow flag with its own clear.
//   clk       in  system clock
//   reset     in  synchronous active-high reset, clears all state
//   en        in  count enable (prescaler advances only when high)
//   load      in  one-cycle strobe: take ld_sec/ld_min/ld_hr
//   ld_sec    in  preload seconds (clamped to SEC_MAX)
//   ld_min    in  preload minutes (clamped to MIN_MAX)
//   ld_hr     in  preload hours   (clamped to HR_MAX)
//   rst_ovf   in  clear ovf
//   sec       out seconds, registered
//   min       out minutes, registered
//   hr        out hours, registered
//   tick      out pulse in the cycle each new count becomes visible
//   min_tick  out pulse in the cycle a seconds carry into minutes is visible
//   ovf       out sticky full-scale flag
// ---------------------------------------------------------------------------
module timestamp_counter
    import tc_pkg::*;
#(
    parameter int PRESCALE = 1,
    parameter int SEC_MAX  = SEC_MAX_DEF,
    parameter int MIN_MAX  = MIN_MAX_DEF,
    parameter int HR_MAX   = HR_MAX_DEF,
    parameter int SEC_W    = SEC_W_DEF,
    parameter int MIN_W    = MIN_W_DEF,
    parameter int HR_W     = HR_W_DEF,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [SEC_W-1:0] ld_sec,
    input  logic [MIN_W-1:0] ld_min,
    input  logic [HR_W-1:0]  ld_hr,
    input  logic             rst_ovf,
    output logic [SEC_W-1:0] sec,
    output logic [MIN_W-1:0] min,
    output logic [HR_W-1:0]  hr,
    output logic             tick,
    output logic             min_tick,
    output logic             ovf
);

    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_MAX);
    localparam logic [MIN_W-1:0] MIN_LAST = MIN_W'(MIN_MAX);
    localparam logic [HR_W-1:0]  HR_LAST  = HR_W'(HR_MAX);
    localparam logic             SAT      = (SATURATE != 0);

    logic [SEC_W-1:0] sec_q, sec_d;
    logic [MIN_W-1:0] min_q, min_d;
    logic [HR_W-1:0]  hr_q,  hr_d;
    logic             tick_q, tick_d;
    logic             min_tick_q, min_tick_d;
    logic             ovf_q, ovf_d;

    logic             inc;
    logic             sec_at_max;
    logic             min_at_max;
    logic             hr_at_max;
    logic             full_scale;

    logic [SEC_W-1:0] ld_sec_c;
    logic [MIN_W-1:0] ld_min_c;
    logic [HR_W-1:0]  ld_hr_c;

    // load doubles as the prescaler restart, which also drops a coincident inc.
    tc_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clr   (load),
        .inc   (inc)
    );

    assign sec_at_max = (sec_q == SEC_LAST);
    assign min_at_max = (min_q == MIN_LAST);
    assign hr_at_max  = (hr_q  == HR_LAST);
    assign full_scale = inc && sec_at_max && min_at_max && hr_at_max;

    assign ld_sec_c = (ld_sec > SEC_LAST) ? SEC_LAST : ld_sec;
    assign ld_min_c = (ld_min > MIN_LAST) ? MIN_LAST : ld_min;
    assign ld_hr_c  = (ld_hr  > HR_LAST)  ? HR_LAST  : ld_hr;

    // Carry chain for the time fields.
    always_comb begin
        sec_d = sec_q;
        min_d = min_q;
        hr_d  = hr_q;
        if (load) begin
            sec_d = ld_sec_c;
            min_d = ld_min_c;
            hr_d  = ld_hr_c;
        end else if (inc) begin
            if (full_scale) begin
                if (!SAT) begin
                    sec_d = '0;
                    min_d = '0;
                    hr_d  = '0;
                end
            end else if (sec_at_max) begin
                sec_d = '0;
                if (min_at_max) begin
                    min_d = '0;
                    hr_d  = hr_q + HR_W'(1);
                end else begin
                    min_d = min_q + MIN_W'(1);
                end
            end else begin
                sec_d = sec_q + SEC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sec_q <= '0;
            min_q <= '0;
            hr_q  <= '0;
        end else begin
            sec_q <= sec_d;
            min_q <= min_d;
            hr_q  <= hr_d;
        end
    end

    // A saturated hold at full scale still ticks but has no seconds carry.
    always_comb begin
        tick_d     = inc;
        min_tick_d = inc && sec_at_max && !(full_scale && SAT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q     <= 1'b0;
            min_tick_q <= 1'b0;
        end else begin
            tick_q     <= tick_d;
            min_tick_q <= min_tick_d;
        end
    end

    // A full-scale event beats a same-cycle clear.
    always_comb begin
        ovf_d = ovf_q;
        if (full_scale) begin
            ovf_d = 1'b1;
        end else if (rst_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign sec      = sec_q;
    assign min      = min_q;
    assign hr       = hr_q;
    assign tick     = tick_q;
    assign min_tick = min_tick_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_timestamp_counter.sv
// ---------------------------------------------------------------------------
// tb_timestamp_counter
// Four counters share one stimulus stream:
//   inst 0: PRESCALE=4 wrap, inst 1: PRESCALE=1 wrap,
//   inst 2: PRESCALE=1 saturate, inst 3: PRESCALE=3 wrap.
// A model tracks elapsed seconds as a single integer and is compared with
// every instance on each falling edge; literal checks pin key points.
// ---------------------------------------------------------------------------
module tb_timestamp_counter;

    localparam int NI = 4;
    localparam int FS = 24 * 60 * 60;

    int ps_of  [NI] = '{4, 1, 1, 3};
    int sat_of [NI] = '{0, 0, 1, 0};

    logic clk = 1'b0;
    logic reset, en, load, rst_ovf;
    logic [5:0] ld_sec, ld_min;
    logic [4:0] ld_hr;

    logic [NI-1:0][5:0] o_sec, o_min;
    logic [NI-1:0][4:0] o_hr;
    logic [NI-1:0]      o_tick, o_mtick, o_ovf;

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    int m_t    [NI] = '{0, 0, 0, 0};
    int m_p    [NI] = '{0, 0, 0, 0};
    bit m_tick [NI] = '{0, 0, 0, 0};
    bit m_mt   [NI] = '{0, 0, 0, 0};
    bit m_ovf  [NI] = '{0, 0, 0, 0};

    always #5 clk = ~clk;

    timestamp_counter #(.PRESCALE(4), .SATURATE(0)) u_dut0 (
        .clk(clk), .reset(reset), .en(en), .load(load), .ld_sec(ld_sec), .ld_min(ld_min),
        .ld_hr(ld_hr), .rst_ovf(rst_ovf), .sec(o_sec[0]), .min(o_min[0]), .hr(o_hr[0]),
        .tick(o_tick[0]), .min_tick(o_mtick[0]), .ovf(o_ovf[0]));
    timestamp_counter #(.PRESCALE(1), .SATURATE(0)) u_dut1 (
        .clk(clk), .reset(reset), .en(en), .load(load), .ld_sec(ld_sec), .ld_min(ld_min),
        .ld_hr(ld_hr), .rst_ovf(rst_ovf), .sec(o_sec[1]), .min(o_min[1]), .hr(o_hr[1]),
        .tick(o_tick[1]), .min_tick(o_mtick[1]), .ovf(o_ovf[1]));
    timestamp_counter #(.PRESCALE(1), .SATURATE(1)) u_dut2 (
        .clk(clk), .reset(reset), .en(en), .load(load), .ld_sec(ld_sec), .ld_min(ld_min),
        .ld_hr(ld_hr), .rst_ovf(rst_ovf), .sec(o_sec[2]), .min(o_min[2]), .hr(o_hr[2]),
        .tick(o_tick[2]), .min_tick(o_mtick[2]), .ovf(o_ovf[2]));
    timestamp_counter #(.PRESCALE(3), .SATURATE(0)) u_dut3 (
        .clk(clk), .reset(reset), .en(en), .load(load), .ld_sec(ld_sec), .ld_min(ld_min),
        .ld_hr(ld_hr), .rst_ovf(rst_ovf), .sec(o_sec[3]), .min(o_min[3]), .hr(o_hr[3]),
        .tick(o_tick[3]), .min_tick(o_mtick[3]), .ovf(o_ovf[3]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: time is total seconds since 0:0:0; fields are derived by div/mod.
    task automatic model_step();
        int  s, mi, h, t;
        bit  inc, full;
        for (int i = 0; i < NI; i++) begin
            if (reset) begin
                m_t[i] = 0; m_p[i] = 0; m_tick[i] = 0; m_mt[i] = 0; m_ovf[i] = 0;
            end else if (load) begin
                s  = (ld_sec > 6'd59) ? 59 : int'(ld_sec);
                mi = (ld_min > 6'd59) ? 59 : int'(ld_min);
                h  = (ld_hr  > 5'd23) ? 23 : int'(ld_hr);
                m_t[i] = (h * 60 + mi) * 60 + s;
                m_p[i] = 0; m_tick[i] = 0; m_mt[i] = 0;
                if (rst_ovf) m_ovf[i] = 0;
            end else begin
                inc = en && (m_p[i] == ps_of[i] - 1);
                if (en) m_p[i] = (m_p[i] + 1) % ps_of[i];
                t    = m_t[i];
                full = inc && (t == FS - 1);
                m_tick[i] = inc;
                m_mt[i]   = inc && (t % 60 == 59) && !(full && sat_of[i] != 0);
                if (inc) m_t[i] = full ? ((sat_of[i] != 0) ? FS - 1 : 0) : t + 1;
                if (full) m_ovf[i] = 1;
                else if (rst_ovf) m_ovf[i] = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("i%0d sec", i),  32'(o_sec[i]),   32'(m_t[i] % 60));
                chk($sformatf("i%0d min", i),  32'(o_min[i]),   32'((m_t[i] / 60) % 60));
                chk($sformatf("i%0d hr", i),   32'(o_hr[i]),    32'(m_t[i] / 3600));
                chk($sformatf("i%0d tick", i), 32'(o_tick[i]),  32'(m_tick[i]));
                chk($sformatf("i%0d mtick", i), 32'(o_mtick[i]), 32'(m_mt[i]));
                chk($sformatf("i%0d ovf", i),  32'(o_ovf[i]),   32'(m_ovf[i]));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int h, input int mi, input int s);
        load = 1'b1; ld_hr = 5'(h); ld_min = 6'(mi); ld_sec = 6'(s);
        cyc(1);
        load = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nt;
        reset = 1'b1; en = 1'b0; load = 1'b0; rst_ovf = 1'b0;
        ld_sec = '0; ld_min = '0; ld_hr = '0;
        cyc(2);
        chk_on = 1'b1;
        chk("reset sec", 32'(o_sec[0]), 0);
        chk("reset tick", 32'(o_tick[0]), 0);
        chk("reset ovf", 32'(o_ovf[0]), 0);

        // Prescale by 4 from reset
        reset = 1'b0; en = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            cyc(1);
            if (k == 3) chk("ps4 tick@3", 32'(o_tick[0]), 0);
            if (k == 4) begin
                chk("ps4 sec@4", 32'(o_sec[0]), 1);
                chk("ps4 tick@4", 32'(o_tick[0]), 1);
            end
        end
        chk("ps4 sec@60", 32'(o_sec[0]), 15);
        chk("ps4 ovf@60", 32'(o_ovf[0]), 0);
        chk("ps1 min@60", 32'(o_min[1]), 1);

        // Hour carry from 0:59:58
        en = 1'b0;
        do_load(0, 59, 58);
        chk("ld sec", 32'(o_sec[1]), 58);
        chk("ld min", 32'(o_min[1]), 59);
        en = 1'b1;
        cyc(1);
        chk("carry sec59", 32'(o_sec[1]), 59);
        chk("carry mtick0", 32'(o_mtick[1]), 0);
        cyc(1);
        chk("carry hr", 32'(o_hr[1]), 1);
        chk("carry min", 32'(o_min[1]), 0);
        chk("carry sec", 32'(o_sec[1]), 0);
        chk("carry mtick", 32'(o_mtick[1]), 1);
        en = 1'b0;
        cyc(1);
        chk("carry mtick off", 32'(o_mtick[1]), 0);

        // Full scale: wrap vs saturate
        do_load(23, 59, 59);
        en = 1'b1;
        cyc(1);
        en = 1'b0;
        chk("wrap hr", 32'(o_hr[1]), 0);
        chk("wrap sec", 32'(o_sec[1]), 0);
        chk("wrap ovf", 32'(o_ovf[1]), 1);
        chk("sat hr", 32'(o_hr[2]), 23);
        chk("sat ovf", 32'(o_ovf[2]), 1);
        rst_ovf = 1'b1;
        cyc(1);
        rst_ovf = 1'b0;
        chk("ovf cleared", 32'(o_ovf[1]), 0);
        en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            chk("ovf stays 0", 32'(o_ovf[1]), 0);
        end
        en = 1'b0;
        chk("wrap sec10", 32'(o_sec[1]), 10);

        // Saturate: three incs at full scale
        rst_ovf = 1'b1;
        do_load(23, 59, 59);
        rst_ovf = 1'b0;
        chk("sat ovf pre", 32'(o_ovf[2]), 0);
        en = 1'b1; nt = 0;
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            nt += int'(o_tick[2]);
        end
        en = 1'b0;
        cyc(1);
        nt += int'(o_tick[2]);
        chk("sat ticks", 32'(nt), 3);
        chk("sat hold hr", 32'(o_hr[2]), 23);
        chk("sat hold min", 32'(o_min[2]), 59);
        chk("sat hold sec", 32'(o_sec[2]), 59);
        chk("sat hold ovf", 32'(o_ovf[2]), 1);

        // Set beats clear; load clamping
        rst_ovf = 1'b1;
        cyc(1);
        rst_ovf = 1'b0;
        chk("pre race ovf", 32'(o_ovf[1]), 0);
        do_load(23, 59, 59);
        en = 1'b1; rst_ovf = 1'b1;
        cyc(1);
        en = 1'b0; rst_ovf = 1'b0;
        chk("race ovf", 32'(o_ovf[1]), 1);
        chk("race sec", 32'(o_sec[1]), 0);
        do_load(31, 63, 63);
        chk("clamp sec", 32'(o_sec[1]), 59);
        chk("clamp min", 32'(o_min[1]), 59);
        chk("clamp hr", 32'(o_hr[1]), 23);

        // Prescale by 3 with enable gaps; reset mid-count
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        en = 1'b1;
        cyc(2);
        en = 1'b0;
        cyc(3);
        chk("ps3 hold tick", 32'(o_tick[3]), 0);
        chk("ps3 hold sec", 32'(o_sec[3]), 0);
        en = 1'b1;
        cyc(1);
        en = 1'b0;
        chk("ps3 sec", 32'(o_sec[3]), 1);
        chk("ps3 tick", 32'(o_tick[3]), 1);
        do_load(0, 5, 17);
        en = 1'b1;
        cyc(1);
        chk("mid sec", 32'(o_sec[3]), 17);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0; en = 1'b0;
        chk("rst sec", 32'(o_sec[3]), 0);
        chk("rst min", 32'(o_min[3]), 0);
        chk("rst tick", 32'(o_tick[3]), 0);
        chk("rst ovf", 32'(o_ovf[1]), 0);
        en = 1'b1;
        cyc(2);
        chk("rst pcnt tick2", 32'(o_tick[3]), 0);
        cyc(1);
        chk("rst pcnt tick3", 32'(o_tick[3]), 1);
        chk("rst pcnt sec", 32'(o_sec[3]), 1);
        en = 1'b0;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
